// File: rtl/zx_clk_pkg.sv
// Speed encodings and the request clamp shared by the ZX CPU clock generator.
package zx_clk_pkg;

  localparam int SPD_W = 2;

  typedef enum logic [SPD_W-1:0] {
    SPD_14M  = 2'd0,
    SPD_7M   = 2'd1,
    SPD_3M5  = 2'd2,
    SPD_1M75 = 2'd3
  } spd_e;

  // Requests above the slowest supported divisor saturate instead of wrapping.
  function automatic int clamp_shift(input int sel, input int max_shift);
    return (sel > max_shift) ? max_shift : sel;
  endfunction

endpackage

// File: rtl/zx_sync2.sv
// Two-flop synchroniser on the falling edge of the master clock, with a reset load value.
module zx_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/zx_cpuclk_gen.sv
// Glitch-free Z80 clock divider (CLK_14MHZ / 2^shift) with stretching and edge strobes.
module zx_cpuclk_gen
  import zx_clk_pkg::*;
#(
  parameter int MAX_SHIFT     = 3,
  parameter int SEL_W         = 2,
  parameter int DEFAULT_SHIFT = int'(SPD_3M5)
) (
  input  logic             CLK_14MHZ,
  input  logic             CPU_RESET,
  input  logic [SEL_W-1:0] speed_sel,
  input  logic             stall_n,
  output logic             CPU_CLK,
  output logic             cpu_rise,
  output logic             cpu_fall,
  output logic [SEL_W-1:0] cur_shift,
  output logic             busy
);

  localparam logic [SEL_W-1:0]     RST_SHIFT = SEL_W'(DEFAULT_SHIFT);
  localparam logic [MAX_SHIFT-1:0] CNT_MAX   = '1;

  logic [SEL_W-1:0]     sel_sync;
  logic [SEL_W-1:0]     req_shift;
  logic [SEL_W-1:0]     target;
  logic [MAX_SHIFT-1:0] cnt;
  logic [MAX_SHIFT-1:0] cnt_inc;
  logic                 clk_q;
  logic                 pass_en;
  logic                 div_nxt;
  logic                 fast;
  logic                 wrap;
  logic                 stretch;

  zx_sync2 #(.W(SEL_W)) u_sync (
    .clk     (CLK_14MHZ),
    .rst_n   (CPU_RESET),
    .rst_val (RST_SHIFT),
    .d       (speed_sel),
    .q       (sel_sync)
  );

  assign req_shift = SEL_W'(clamp_shift(int'(sel_sync), MAX_SHIFT));
  assign cnt_inc   = cnt + MAX_SHIFT'(1);
  assign fast      = (cur_shift == '0);
  assign wrap      = (cnt == CNT_MAX);

  always_comb begin
    div_nxt = 1'b0;
    for (int i = 1; i <= MAX_SHIFT; i++) begin
      if (int'(cur_shift) == i) div_nxt = cnt_inc[i-1];
    end
  end

  // Stretch only where the divided clock is about to fall; a low phase always runs out.
  assign stretch = !fast && !stall_n && clk_q && !div_nxt;

  always_ff @(negedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      cnt       <= '0;
      clk_q     <= 1'b0;
      cur_shift <= RST_SHIFT;
      target    <= RST_SHIFT;
      busy      <= 1'b0;
      pass_en   <= (DEFAULT_SHIFT == 0);
      cpu_rise  <= 1'b0;
      cpu_fall  <= 1'b0;
    end else begin
      if (req_shift != cur_shift) begin
        busy   <= 1'b1;
        target <= req_shift;
      end else begin
        busy   <= 1'b0;
      end

      if (stretch) begin
        cpu_rise <= 1'b0;
        cpu_fall <= 1'b0;
      end else begin
        cnt <= cnt_inc;
        // At the wrap every divided clock falls together, so swapping the divisor here cannot runt.
        if (wrap && busy) begin
          cur_shift <= target;
          busy      <= 1'b0;
          pass_en   <= (target == '0);
          clk_q     <= 1'b0;
          cpu_rise  <= (target == '0);
          cpu_fall  <= (target == '0) | clk_q;
        end else begin
          clk_q    <= div_nxt;
          cpu_rise <= fast | (div_nxt & ~clk_q);
          cpu_fall <= fast | (~div_nxt & clk_q);
        end
      end
    end
  end

  // pass_en and clk_q are never high together and only change while CLK_14MHZ is low.
  assign CPU_CLK = (pass_en & CLK_14MHZ) | clk_q;

endmodule
